// File: rtl/tiny_alu_pkg.sv
// Shared types and widths for the tiny_alu block: opcodes, control states
// and the operand/result widths used by the top and the multiplier.
package tiny_alu_pkg;

  localparam int OPND_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [2:0] {
    NO_OP = 3'd0,
    ADD   = 3'd1,
    AND   = 3'd2,
    XOR   = 3'd3,
    MUL   = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    MUL3 = 2'd3
  } state_e;

  // 9-bit sum with the carry kept in bit 8, zero-extended to the result width.
  function automatic logic [RES_W-1:0] add_ext(input logic [OPND_W-1:0] a,
                                               input logic [OPND_W-1:0] b);
    logic [OPND_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return {7'b0, sum};
  endfunction

endpackage

// File: rtl/tiny_alu_if.sv
// Operand/opcode request and result/done response bundle of tiny_alu.
interface tiny_alu_if;

  logic [tiny_alu_pkg::OPND_W-1:0] A;
  logic [tiny_alu_pkg::OPND_W-1:0] B;
  logic [2:0]                      op;
  logic                            start;
  logic                            done;
  logic [tiny_alu_pkg::RES_W-1:0]  result;

  modport master (
    output A, B, op, start,
    input  done, result
  );

  modport slave (
    input  A, B, op, start,
    output done, result
  );

endinterface

// File: rtl/tiny_alu_mult.sv
// Three-stage registered unsigned 8x8 multiplier with a matching valid pipe.
// Stage 1 latches operands, stage 2 forms two nibble partial products, stage 3 sums.
module tiny_alu_mult
  import tiny_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic              out_valid,
  output logic [RES_W-1:0]  product
);

  logic              s1_valid_r;
  logic [OPND_W-1:0] a_r;
  logic [OPND_W-1:0] b_r;
  logic              s2_valid_r;
  logic [11:0]       pp_lo_r;
  logic [11:0]       pp_hi_r;
  logic              s3_valid_r;
  logic [RES_W-1:0]  prod_r;
  logic [11:0]       pp_lo_s;
  logic [11:0]       pp_hi_s;
  logic [RES_W-1:0]  sum_s;

  // Partial products on the low and high nibble of b, recombined with a 4-bit shift.
  always_comb begin
    pp_lo_s = {4'b0, a_r} * {8'b0, b_r[3:0]};
    pp_hi_s = {4'b0, a_r} * {8'b0, b_r[7:4]};
    sum_s   = {4'b0, pp_lo_r} + {pp_hi_r, 4'b0};
  end

  // Pipeline registers; reset clears valids so an aborted product never emerges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      a_r        <= 8'h00;
      b_r        <= 8'h00;
      s2_valid_r <= 1'b0;
      pp_lo_r    <= 12'h000;
      pp_hi_r    <= 12'h000;
      s3_valid_r <= 1'b0;
      prod_r     <= 16'h0000;
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
      end else begin
        a_r <= a_r;
        b_r <= b_r;
      end
      s2_valid_r <= s1_valid_r;
      pp_lo_r    <= pp_lo_s;
      pp_hi_r    <= pp_hi_s;
      s3_valid_r <= s2_valid_r;
      prod_r     <= sum_s;
    end
  end

  assign out_valid = s3_valid_r;
  assign product   = prod_r;

endmodule

// File: rtl/tiny_alu.sv
// 8-bit ALU with start/done handshake: add/and/xor finish in one cycle,
// multiply runs through the three-stage multiplier while the FSM is busy.
module tiny_alu
  import tiny_alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  tiny_alu_if.slave  bus
);

  state_e           state_r;
  logic [RES_W-1:0] result_r;
  logic             done_r;

  logic             accept_s;
  logic             alu_hit_s;
  logic             mul_go_s;
  logic [RES_W-1:0] alu_res_s;
  logic             mul_valid_s;
  logic [RES_W-1:0] mul_prod_s;

  // Decode an accepted request; no_op and reserved codes are taken but do nothing.
  always_comb begin
    accept_s  = 1'b0;
    alu_hit_s = 1'b0;
    mul_go_s  = 1'b0;
    alu_res_s = 16'h0000;
    if (bus.start && (state_r == IDLE)) begin
      accept_s = 1'b1;
      case (bus.op)
        ADD: begin
          alu_hit_s = 1'b1;
          alu_res_s = add_ext(bus.A, bus.B);
        end
        AND: begin
          alu_hit_s = 1'b1;
          alu_res_s = {8'h00, bus.A & bus.B};
        end
        XOR: begin
          alu_hit_s = 1'b1;
          alu_res_s = {8'h00, bus.A ^ bus.B};
        end
        MUL: begin
          mul_go_s = 1'b1;
        end
        NO_OP: begin
          alu_hit_s = 1'b0;
        end
        default: begin
          alu_hit_s = 1'b0;
        end
      endcase
    end else begin
      accept_s = 1'b0;
    end
  end

  tiny_alu_mult u_mult (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (mul_go_s),
    .a         (bus.A),
    .b         (bus.B),
    .out_valid (mul_valid_s),
    .product   (mul_prod_s)
  );

  // Control FSM with registered result and done strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      result_r <= 16'h0000;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= alu_hit_s;
          if (alu_hit_s) begin
            result_r <= alu_res_s;
          end else begin
            result_r <= result_r;
          end
          if (accept_s && mul_go_s) begin
            state_r <= MUL1;
          end else begin
            state_r <= IDLE;
          end
        end
        MUL1: begin
          done_r  <= 1'b0;
          state_r <= MUL2;
        end
        MUL2: begin
          done_r  <= 1'b0;
          state_r <= MUL3;
        end
        MUL3: begin
          // The multiplier's valid lines up with this state by construction.
          done_r  <= mul_valid_s;
          state_r <= IDLE;
          if (mul_valid_s) begin
            result_r <= mul_prod_s;
          end else begin
            result_r <= result_r;
          end
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_tiny_alu.sv
// Directed self-checking bench for tiny_alu with hand-computed expectations.
module tb_tiny_alu;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  tiny_alu_if bus();

  tiny_alu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0]  s_op [3];
  logic [7:0]  s_a  [3];
  logic [7:0]  s_b  [3];
  logic [15:0] s_r  [3];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    s_op[0] = 3'd2; s_a[0] = 8'hF0; s_b[0] = 8'h3C; s_r[0] = 16'h0030;
    s_op[1] = 3'd3; s_a[1] = 8'hF0; s_b[1] = 8'h3C; s_r[1] = 16'h00CC;
    s_op[2] = 3'd1; s_a[2] = 8'h10; s_b[2] = 8'h20; s_r[2] = 16'h0030;

    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;
    tick();
    tick();
    check_val("reset_result", bus.result, 16'h0000);
    check_val("reset_done", {15'b0, bus.done}, 16'h0000);
    reset_n = 1'b1;
    tick();

    // add with carry out
    bus.start = 1'b1; bus.op = 3'd1; bus.A = 8'hFF; bus.B = 8'h01;
    tick();
    bus.start = 1'b0;
    check_val("add_result", bus.result, 16'h0100);
    check_val("add_done", {15'b0, bus.done}, 16'h0001);
    tick();
    check_val("add_done_drop", {15'b0, bus.done}, 16'h0000);
    check_val("add_hold", bus.result, 16'h0100);

    // multiply, with an add presented while busy
    bus.start = 1'b1; bus.op = 3'd4; bus.A = 8'hFF; bus.B = 8'hFF;
    tick();
    check_val("mul_e0_done", {15'b0, bus.done}, 16'h0000);
    check_val("mul_e0_result", bus.result, 16'h0100);
    bus.op = 3'd1; bus.A = 8'h01; bus.B = 8'h02;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_val($sformatf("mul_ff_done_%0d", k), {15'b0, bus.done}, (k == 3) ? 16'h0001 : 16'h0000);
      check_val($sformatf("mul_ff_result_%0d", k), bus.result, (k == 3) ? 16'hFE01 : 16'h0100);
    end
    bus.start = 1'b0;
    tick();
    check_val("mul_ff_done_drop", {15'b0, bus.done}, 16'h0000);
    check_val("mul_ff_hold", bus.result, 16'hFE01);

    // back-to-back single-cycle stream
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.op = s_op[i]; bus.A = s_a[i]; bus.B = s_b[i];
      tick();
      check_val($sformatf("stream_result_%0d", i), bus.result, s_r[i]);
      check_val($sformatf("stream_done_%0d", i), {15'b0, bus.done}, 16'h0001);
    end
    bus.start = 1'b0;
    tick();
    check_val("stream_done_drop", {15'b0, bus.done}, 16'h0000);

    // no_op and reserved opcode are discarded
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 8'h55; bus.B = 8'hAA;
    tick();
    check_val("noop_done", {15'b0, bus.done}, 16'h0000);
    check_val("noop_result", bus.result, 16'h0030);
    bus.op = 3'd6;
    tick();
    check_val("rsvd_done", {15'b0, bus.done}, 16'h0000);
    check_val("rsvd_result", bus.result, 16'h0030);
    bus.start = 1'b0;
    tick();

    // asynchronous reset in MUL2
    bus.start = 1'b1; bus.op = 3'd4; bus.A = 8'h12; bus.B = 8'h34;
    tick();
    bus.start = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_val("areset_result", bus.result, 16'h0000);
    check_val("areset_done", {15'b0, bus.done}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val($sformatf("no_stale_done_%0d", k), {15'b0, bus.done}, 16'h0000);
    end
    check_val("post_reset_result", bus.result, 16'h0000);

    // multiply then add; add lost while busy, accepted at E+4
    bus.start = 1'b1; bus.op = 3'd4; bus.A = 8'h12; bus.B = 8'h34;
    tick();
    bus.op = 3'd1; bus.A = 8'h01; bus.B = 8'h01;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_val($sformatf("mul_12_done_%0d", k), {15'b0, bus.done}, (k == 3) ? 16'h0001 : 16'h0000);
      check_val($sformatf("mul_12_result_%0d", k), bus.result, (k == 3) ? 16'h03A8 : 16'h0000);
    end
    tick();
    check_val("add_after_mul_result", bus.result, 16'h0002);
    check_val("add_after_mul_done", {15'b0, bus.done}, 16'h0001);
    bus.start = 1'b0;
    tick();
    check_val("final_done_drop", {15'b0, bus.done}, 16'h0000);
    check_val("final_hold", bus.result, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
